// File: rtl/max_unpool_stream_if.sv
// Handshake bundle for the 2x2 max-unpooling stage: pooled input stream in,
// upsampled output stream out.
interface max_unpool_stream_if #(
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_idx;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_eol;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_idx, out_ready,
    input  in_ready, out_valid, out_data, out_eol, out_last
  );

  modport slave (
    input  in_valid, in_data, in_idx, out_ready,
    output in_ready, out_valid, out_data, out_eol, out_last
  );
endinterface

// File: rtl/max_unpool_stream.sv
// Streaming 2x2 max-unpooling: buffers one pooled row, then emits the two
// upsampled rows, placing each value at its argmax slot and zero elsewhere.
module max_unpool_stream #(
  parameter int DATA_W = 4,
  parameter int POOL_W = 8,
  parameter int POOL_H = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  max_unpool_stream_if.slave  bus
);
  localparam int AW = (POOL_W > 1) ? $clog2(POOL_W) : 1;
  localparam int CW = AW + 1;
  localparam int RW = (POOL_H > 1) ? $clog2(POOL_H) : 1;
  localparam logic [CW-1:0] IN_LAST  = CW'(POOL_W - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(2 * POOL_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(POOL_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, TOP, BOT} state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  col_cnt;
  logic [RW-1:0]                  row_cnt;
  logic [POOL_W-1:0][DATA_W-1:0]  buf_data;
  logic [POOL_W-1:0][1:0]         buf_idx;

  logic          emitting;
  logic          in_fire;
  logic          out_fire;
  logic          slot_match;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign emitting = (state_q == TOP) || (state_q == BOT);
  assign in_fire  = (state_q == FILL) && bus.in_valid;
  assign out_fire = emitting && bus.out_ready;
  assign wr_addr  = col_cnt[AW-1:0];
  assign rd_addr  = col_cnt[AW:1];

  // Row parity comes from the state, column parity from the output column.
  assign slot_match = (buf_idx[rd_addr] == {state_q == BOT, col_cnt[0]});

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = emitting;
  assign bus.out_data  = (emitting && slot_match) ? buf_data[rd_addr] : '0;
  assign bus.out_eol   = emitting && (col_cnt == OUT_LAST);
  assign bus.out_last  = bus.out_eol && (state_q == BOT) && (row_cnt == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = FILL;
      FILL: if (in_fire && (col_cnt == IN_LAST)) state_d = TOP;
      TOP:  if (out_fire && (col_cnt == OUT_LAST)) state_d = BOT;
      BOT:  if (out_fire && (col_cnt == OUT_LAST)) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      buf_data <= '0;
      buf_idx  <= '0;
    end else if (in_fire) begin
      buf_data[wr_addr] <= bus.in_data;
      buf_idx[wr_addr]  <= bus.in_idx;
      col_cnt           <= (col_cnt == IN_LAST) ? '0 : col_cnt + 1'b1;
    end else if (out_fire) begin
      col_cnt <= (col_cnt == OUT_LAST) ? '0 : col_cnt + 1'b1;
      if ((state_q == BOT) && (col_cnt == OUT_LAST)) begin
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_max_unpool_stream.sv
// Directed bench for max_unpool_stream: table-driven single-row vectors plus
// full-frame, backpressure, saturation and mid-frame reset sequences.
module tb_max_unpool_stream;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;

  max_unpool_stream_if #(.DATA_W(4)) bus ();

  max_unpool_stream #(.DATA_W(4), .POOL_W(8), .POOL_H(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] in_data;
    logic [1:0] in_idx;
    logic [3:0] r0_even;
    logic [3:0] r0_odd;
    logic [3:0] r1_even;
    logic [3:0] r1_odd;
  } vec_t;

  vec_t       tbl [8];
  logic [3:0] fd [8][8];
  logic [1:0] fi [8][8];
  logic [3:0] ref_o [16][16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output is zero and unflagged whenever no beat is offered.
  always @(negedge clk) begin
    if (!bus.out_valid) begin
      checks++;
      if (bus.out_data != 4'd0 || bus.out_eol || bus.out_last) begin
        failures++;
        $display("FAIL idle_zero: data=%0d eol=%0d last=%0d required 0/0/0",
                 bus.out_data, bus.out_eol, bus.out_last);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic build_ref();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) ref_o[r][c] = 4'd0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        ref_o[2*r + int'(fi[r][c][1])][2*c + int'(fi[r][c][0])] = fd[r][c];
  endtask

  task automatic send(input logic [3:0] d, input logic [1:0] idx, input int gap, output int t);
    bit ok;
    ok = 0;
    t  = 0;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_idx   = idx;
    for (int k = 0; k < 500; k++) begin
      if (bus.in_ready) begin
        ok = 1;
        t  = cyc;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic get_beat(input int pct, output logic [3:0] d, output logic eol,
                          output logic last, output int t);
    bit ok, held;
    logic [3:0] hd;
    logic he, hl;
    ok = 0; held = 0; hd = '0; he = 0; hl = 0;
    d = '0; eol = 0; last = 0; t = 0;
    for (int k = 0; k < 1000; k++) begin
      bus.out_ready = ($urandom_range(99) < pct);
      if (bus.out_valid) begin
        if (held) begin
          chk("hold_data", bus.out_data, hd);
          chk("hold_eol", bus.out_eol, he);
          chk("hold_last", bus.out_last, hl);
        end
        if (bus.out_ready) begin
          d = bus.out_data; eol = bus.out_eol; last = bus.out_last;
          t = cyc; ok = 1;
          @(negedge clk);
          break;
        end
        held = 1; hd = bus.out_data; he = bus.out_eol; hl = bus.out_last;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    if (!ok) chk("beat_timeout", 0, 1);
  endtask

  task automatic collect_beat(input int r, input int b, input int pct,
                              inout int out_sum, inout int nz);
    logic [3:0] d;
    logic e, l;
    int t;
    get_beat(pct, d, e, l, t);
    chk($sformatf("data_r%0d_b%0d", r, b), d, ref_o[2*r + b/16][b%16]);
    chk($sformatf("eol_r%0d_b%0d", r, b), e, (b % 16) == 15);
    chk($sformatf("last_r%0d_b%0d", r, b), l, (r == 7) && (b == 31));
    out_sum += int'(d);
    if (d != 4'd0) nz++;
  endtask

  task automatic run_rows(input int nrows, input int gap_max, input int pct,
                          output int in_sum, output int out_sum, output int nz);
    int t;
    in_sum = 0; out_sum = 0; nz = 0;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < 8; c++) begin
        send(fd[r][c], fi[r][c], $urandom_range(gap_max), t);
        in_sum += int'(fd[r][c]);
      end
      for (int b = 0; b < 32; b++) collect_beat(r, b, pct, out_sum, nz);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle_in_ready", bus.in_ready, 0);
    chk("rst_idle_out_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("rst_fill_in_ready", bus.in_ready, 1);
  endtask

  task automatic rand_frame();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        fd[r][c] = 4'($urandom_range(15));
        fi[r][c] = 2'($urandom_range(3));
      end
    build_ref();
  endtask

  initial begin
    int t0, t1, t;
    int in_sum, out_sum, nz;
    logic [3:0] d;
    logic e, l;

    checks = 0; failures = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.in_idx = '0; bus.out_ready = 0;

    tbl[0] = '{4'd1, 2'd0, 4'd1, 4'd0, 4'd0, 4'd0};
    tbl[1] = '{4'd2, 2'd1, 4'd0, 4'd2, 4'd0, 4'd0};
    tbl[2] = '{4'd3, 2'd2, 4'd0, 4'd0, 4'd3, 4'd0};
    tbl[3] = '{4'd4, 2'd3, 4'd0, 4'd0, 4'd0, 4'd4};
    tbl[4] = '{4'd5, 2'd0, 4'd5, 4'd0, 4'd0, 4'd0};
    tbl[5] = '{4'd6, 2'd1, 4'd0, 4'd6, 4'd0, 4'd0};
    tbl[6] = '{4'd7, 2'd2, 4'd0, 4'd0, 4'd7, 4'd0};
    tbl[7] = '{4'd8, 2'd3, 4'd0, 4'd0, 4'd0, 4'd8};

    // Reset values held during reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_eol", bus.out_eol, 0);
    chk("rst_out_last", bus.out_last, 0);
    do_reset();
    repeat (5) @(negedge clk);
    chk("no_input_out_valid", bus.out_valid, 0);

    // Single row, table-driven
    do_reset();
    t0 = 0;
    for (int j = 0; j < 8; j++) begin
      send(tbl[j].in_data, tbl[j].in_idx, 0, t);
      if (j == 0) t0 = t;
    end
    chk("row_latency_out_valid", bus.out_valid, 1);
    chk("row_latency_in_ready", bus.in_ready, 0);
    t1 = 0;
    for (int b = 0; b < 32; b++) begin
      int j;
      logic [3:0] exp_d;
      j = (b % 16) / 2;
      if (b < 16) exp_d = (b % 2 == 0) ? tbl[j].r0_even : tbl[j].r0_odd;
      else        exp_d = (b % 2 == 0) ? tbl[j].r1_even : tbl[j].r1_odd;
      get_beat(100, d, e, l, t1);
      chk($sformatf("tbl_data_b%0d", b), d, exp_d);
      chk($sformatf("tbl_eol_b%0d", b), e, (b == 15) || (b == 31));
      chk($sformatf("tbl_last_b%0d", b), l, 0);
    end
    chk("row_phase_cycles", t1 - t0 + 1, 40);
    chk("row_back_to_fill", bus.in_ready, 1);

    // Random frames with gaps and 50% backpressure, back to back
    do_reset();
    for (int f = 0; f < 2; f++) begin
      rand_frame();
      run_rows(8, 2, 50, in_sum, out_sum, nz);
      chk($sformatf("frame%0d_sum", f), out_sum, in_sum);
      chk($sformatf("frame%0d_no_gap", f), bus.in_ready, 1);
    end

    // Output stall at column 5 of TOP
    do_reset();
    for (int c = 0; c < 8; c++) begin fd[0][c] = 4'(c + 1); fi[0][c] = 2'd1; end
    for (int r = 1; r < 8; r++)
      for (int c = 0; c < 8; c++) begin fd[r][c] = 4'd0; fi[r][c] = 2'd0; end
    build_ref();
    for (int c = 0; c < 8; c++) send(fd[0][c], fi[0][c], 0, t);
    in_sum = 0; out_sum = 0; nz = 0;
    for (int b = 0; b < 5; b++) collect_beat(0, b, 100, out_sum, nz);
    for (int k = 0; k < 10; k++) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_data", bus.out_data, 3);
      chk("stall_eol", bus.out_eol, 0);
      @(negedge clk);
    end
    for (int b = 5; b < 32; b++) collect_beat(0, b, 100, out_sum, nz);
    chk("stall_sum", out_sum, 36);

    // Saturated frame: every value F at slot 3
    do_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin fd[r][c] = 4'hF; fi[r][c] = 2'd3; end
    build_ref();
    run_rows(8, 0, 100, in_sum, out_sum, nz);
    chk("sat_nonzero_count", nz, 64);
    chk("sat_sum", out_sum, 64 * 15);

    // Reset mid-BOT of pooled row 3, then a clean frame
    do_reset();
    rand_frame();
    run_rows(3, 1, 100, in_sum, out_sum, nz);
    for (int c = 0; c < 8; c++) send(fd[3][c], fi[3][c], 0, t);
    for (int b = 0; b < 21; b++) collect_beat(3, b, 100, out_sum, nz);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_in_ready", bus.in_ready, 0);
    chk("async_rst_out_data", bus.out_data, 0);
    chk("async_rst_out_eol", bus.out_eol, 0);
    do_reset();
    rand_frame();
    run_rows(8, 1, 70, in_sum, out_sum, nz);
    chk("post_rst_sum", out_sum, in_sum);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/max_unpool_stream.md
Name: max_unpool_stream

Overview:
- Streaming 2x2 max-unpooling stage: the inverse of the CNN 2x2 max-pool.
- Accepts a pooled POOL_H x POOL_W frame in raster order. Each element carries a value plus a 2-bit argmax index.
- Emits the 2*POOL_H x 2*POOL_W upsampled frame in raster order. Each value is placed at its recorded position within its 2x2 block; the other three positions are zero.
- Sits on the decoder/reconstruction side of the CNN datapath, downstream of the argmax-recording pooling stage.

Parameters:
DATA_W, 4, element width in bits
POOL_W, 8, pooled frame width (output width = 2*POOL_W)
POOL_H, 8, pooled frame height (output height = 2*POOL_H)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  pooled element valid
in_ready  output  1  block can accept a pooled element
in_data  input  DATA_W  pooled value
in_idx  input  2  argmax position in 2x2 block: 0=(2i,2j), 1=(2i,2j+1), 2=(2i+1,2j), 3=(2i+1,2j+1)
out_valid  output  1  output element valid
out_ready  input  1  downstream accepts output element
out_data  output  DATA_W  unpooled element
out_eol  output  1  marks last element of an output row (column 2*POOL_W-1)
out_last  output  1  marks last element of the frame (row 2*POOL_H-1, column 2*POOL_W-1)

Behaviour:
- Handshakes:
  - Transfer occurs on a rising edge with valid && ready, on both interfaces.
  - While out_valid && !out_ready, out_data/out_eol/out_last hold stable.
  - No combinational path from out_ready or in_valid to any output.
- Storage and counters:
  - Row buffer: POOL_W entries of {idx[1:0], data[DATA_W-1:0]}.
  - col_cnt: width for 0..2*POOL_W-1.
  - row_cnt: 0..POOL_H-1 (pooled row).
- States:
  - IDLE: in_ready=0, out_valid=0. Always moves to FILL next cycle.
  - FILL: in_ready=1, out_valid=0. Each input transfer writes buf[col_cnt] and increments col_cnt. On transfer with col_cnt==POOL_W-1: col_cnt<=0, go to TOP.
  - TOP: in_ready=0, out_valid=1. Emits output row 2*row_cnt. out_data = buf[col_cnt>>1].data if buf[col_cnt>>1].idx == {1'b0, col_cnt[0]}, else 0. On output transfer, col_cnt increments. On transfer at col_cnt==2*POOL_W-1: col_cnt<=0, go to BOT.
  - BOT: same as TOP, except the match is idx == {1'b1, col_cnt[0]}. Emits row 2*row_cnt+1. On last-column transfer: col_cnt<=0, go to FILL. If row_cnt==POOL_H-1, row_cnt<=0 (frame complete); else row_cnt<=row_cnt+1.
- Flags:
  - out_eol = out_valid && col_cnt==2*POOL_W-1.
  - out_last = out_eol && state==BOT && row_cnt==POOL_H-1.
- Outputs are decoded only from registered state, counters and buffer. out_data=0 whenever out_valid=0.
- Latency and throughput:
  - out_valid rises the cycle after the POOL_W-th input transfer of a row.
  - Minimum per pooled row: POOL_W + 4*POOL_W cycles (40 for defaults).
  - Input is not accepted while emitting; no overlap.
- Back-to-back frames: FILL immediately follows the final BOT beat. No idle gap and no frame-level restart needed.
- Backpressure: out_ready low for any duration stalls the emission in place with no loss or duplication.
- Input stall: in_valid gaps in FILL simply pause the fill; col_cnt holds.
- Sum preservation: every input value appears exactly once in the output. The sum of the output frame equals the sum of the input frame.
- Reset, including mid-frame or mid-handshake:
  - Asynchronously: state=IDLE, col_cnt=0, row_cnt=0, buffer cleared to 0.
  - in_ready=0, out_valid=0, out_data=0, out_eol=0, out_last=0.
  - Partial frame discarded. After release: one IDLE cycle, then in_ready=1.

Test Plan:
- Reset release, default params -> all outputs 0 during reset; in_ready=0 on first cycle after release, 1 on second; out_valid stays 0 with no input.
- Single row, data=j+1, idx=j%4 for j=0..7, out_ready=1 -> out_valid 1 cycle after 8th accept; row 0 = 1,0,0,2,0,0,0,0,5,0,0,6,0,0,0,0; row 1 = 0,0,0,0,3,0,0,4,0,0,0,0,7,0,0,8; out_eol on beats 15 and 31; row phase takes 40 cycles.
- Full 8x8 frame of random data/idx, random out_ready (50%) and in_valid gaps -> 256 outputs match reference model; out_last only on beat 256; each output sum equals its input sum; a second frame follows with no gap.
- out_ready held 0 for 10 cycles mid-TOP at col_cnt=5 -> out_data/out_eol frozen; resumes at col 5, no skip or repeat.
- All inputs data=4'hF, idx=3 -> even output rows all 0; odd rows alternate 0,F; total output nonzero count = 64.
- rst_n pulsed low mid-BOT of pooled row 3 -> out_valid drops asynchronously; after restart, a new 8x8 frame produces a correct 256-beat output with out_last at the end and no stale data.
